control_unit: RTL and testbench

- Combinational MIPS-subset instruction decoder for the two-stage CPU (fetch, then execute/writeback).
- Takes opcode, shamt and funct from the execute-stage instruction.
- Drives ALU op, shift amount, B-operand select, destination select, register-write, hi/lo enable, writeback-source select and GPIO strobes.
- A reset/stall qualifier turns the decoded instruction into a bubble.

---
 rtl/cpu_pkg.sv | 82 ++++++++
 rtl/control_unit.sv | 204 ++++++++++++++++++++
 tb/tb_control_unit.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// cpu_pkg: encodings shared by the control unit, the ALU and the CPU top.
//   - alu_op_e    : ALU operation codes
//   - OP_* / FN_* : MIPS opcode and funct field values
//   - REGSEL_*    : writeback source select
//   - ALUSRC_*    : ALU B-operand select
//   - ctrl_t      : bundle of decoded execute-stage control signals
package cpu_pkg;

  typedef enum logic [3:0] {
    ALU_AND   = 4'b0000,
    ALU_OR    = 4'b0001,
    ALU_XOR   = 4'b0010,
    ALU_NOR   = 4'b0011,
    ALU_ADD   = 4'b0100,
    ALU_SUB   = 4'b0101,
    ALU_MULT  = 4'b0110,
    ALU_MULTU = 4'b0111,
    ALU_SLL   = 4'b1000,
    ALU_SRL   = 4'b1001,
    ALU_SRA   = 4'b1010,
    ALU_SLT   = 4'b1100,
    ALU_SLTU  = 4'b1101
  } alu_op_e;

  // Opcodes (instr[31:26])
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_SLTIU = 6'h0B;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  // Funct codes (instr[5:0])
  localparam logic [5:0] FN_SLL   = 6'h00;
  localparam logic [5:0] FN_SRL   = 6'h02;
  localparam logic [5:0] FN_SRA   = 6'h03;
  localparam logic [5:0] FN_MFHI  = 6'h10;
  localparam logic [5:0] FN_MFLO  = 6'h12;
  localparam logic [5:0] FN_MULT  = 6'h18;
  localparam logic [5:0] FN_MULTU = 6'h19;
  localparam logic [5:0] FN_ADD   = 6'h20;
  localparam logic [5:0] FN_ADDU  = 6'h21;
  localparam logic [5:0] FN_SUB   = 6'h22;
  localparam logic [5:0] FN_SUBU  = 6'h23;
  localparam logic [5:0] FN_AND   = 6'h24;
  localparam logic [5:0] FN_OR    = 6'h25;
  localparam logic [5:0] FN_XOR   = 6'h26;
  localparam logic [5:0] FN_NOR   = 6'h27;
  localparam logic [5:0] FN_SLT   = 6'h2A;
  localparam logic [5:0] FN_SLTU  = 6'h2B;

  // Writeback source select
  localparam logic [1:0] REGSEL_ALU = 2'b00;
  localparam logic [1:0] REGSEL_HI  = 2'b01;
  localparam logic [1:0] REGSEL_LO  = 2'b10;

  // ALU B-operand select
  localparam logic [1:0] ALUSRC_RT   = 2'b00;
  localparam logic [1:0] ALUSRC_SEXT = 2'b01;
  localparam logic [1:0] ALUSRC_ZEXT = 2'b10;

  localparam logic [4:0] LUI_SHAMT = 5'd16;

  typedef struct packed {
    alu_op_e    alu_op;
    logic [4:0] shamt;
    logic       enhilo;
    logic [1:0] regsel;
    logic       regwrite;
    logic       rdrt;
    logic       memwrite;
    logic [1:0] alu_src;
    logic       gpio_out;
    logic       gpio_in;
  } ctrl_t;

endpackage

// File: rtl/control_unit.sv
// control_unit: combinational MIPS-subset decoder for the execute stage.
//
// Ports:
//   clk, rst          clock and asynchronous active-high reset
//   i_type            opcode instr[31:26]
//   shamt             instr[10:6]
//   function_code     funct instr[5:0]
//   stall_FETCH       execute-stage instruction is a bubble
//   alu_op            ALU operation (cpu_pkg::alu_op_e)
//   shamt_EX          shift amount to ALU
//   enhilo_EX         latch hi/lo
//   regsel_EX         writeback source (ALU / hi / lo)
//   regwrite_EX       register-file write enable
//   rdrt_EX           destination select, 0 = rd, 1 = rt
//   memwrite_EX       store strobe
//   alu_src_EX        ALU B source (rt / sign-ext imm / zero-ext imm)
//   GPIO_OUT          latch rt data to gpio_out
//   GPIO_IN           write gpio_in to the destination register
//   illegal           (only with CONTROL_UNIT_ILLEGAL_FLAG_EN) encoding
//                     decoded to the default NOP outside a bubble
//
// Optional feature macro: CONTROL_UNIT_ILLEGAL_FLAG_EN
module control_unit
  import cpu_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] i_type,
  input  logic [4:0] shamt,
  input  logic [5:0] function_code,
  input  logic       stall_FETCH,
  output logic [3:0] alu_op,
  output logic [4:0] shamt_EX,
  output logic       enhilo_EX,
  output logic [1:0] regsel_EX,
  output logic       regwrite_EX,
  output logic       rdrt_EX,
  output logic       memwrite_EX,
  output logic [1:0] alu_src_EX,
  output logic       GPIO_OUT,
`ifdef CONTROL_UNIT_ILLEGAL_FLAG_EN
  output logic       GPIO_IN,
  output logic       illegal
`else
  output logic       GPIO_IN
`endif
);

  // Holds off decode for the first cycle after reset so the instruction
  // register has been loaded once before anything is acted upon.
  logic first_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      first_q <= 1'b1;
    end else begin
      first_q <= 1'b0;
    end
  end

  logic  bubble;
  ctrl_t dec_d;
  ctrl_t ctrl;

  assign bubble = rst | first_q | stall_FETCH;

  always_comb begin
    dec_d        = '0;
    dec_d.alu_op = ALU_AND;
    unique case (i_type)
      OP_RTYPE: begin
        case (function_code)
          FN_ADD, FN_ADDU: begin dec_d.alu_op = ALU_ADD; dec_d.regwrite = 1'b1; end
          FN_SUB, FN_SUBU: begin dec_d.alu_op = ALU_SUB; dec_d.regwrite = 1'b1; end
          FN_AND:  begin dec_d.alu_op = ALU_AND;  dec_d.regwrite = 1'b1; end
          FN_OR:   begin dec_d.alu_op = ALU_OR;   dec_d.regwrite = 1'b1; end
          FN_XOR:  begin dec_d.alu_op = ALU_XOR;  dec_d.regwrite = 1'b1; end
          FN_NOR:  begin dec_d.alu_op = ALU_NOR;  dec_d.regwrite = 1'b1; end
          FN_SLT:  begin dec_d.alu_op = ALU_SLT;  dec_d.regwrite = 1'b1; end
          FN_SLTU: begin dec_d.alu_op = ALU_SLTU; dec_d.regwrite = 1'b1; end
          FN_SLL: begin
            dec_d.alu_op   = ALU_SLL;
            dec_d.shamt    = shamt;
            dec_d.regwrite = 1'b1;
          end
          FN_SRL: begin
            dec_d.alu_op   = ALU_SRL;
            dec_d.shamt    = shamt;
            dec_d.regwrite = 1'b1;
          end
          FN_SRA: begin
            dec_d.alu_op   = ALU_SRA;
            dec_d.shamt    = shamt;
            dec_d.regwrite = 1'b1;
          end
          FN_MULT:  begin dec_d.alu_op = ALU_MULT;  dec_d.enhilo = 1'b1; end
          FN_MULTU: begin dec_d.alu_op = ALU_MULTU; dec_d.enhilo = 1'b1; end
          FN_MFHI:  begin dec_d.regsel = REGSEL_HI; dec_d.regwrite = 1'b1; end
          FN_MFLO:  begin dec_d.regsel = REGSEL_LO; dec_d.regwrite = 1'b1; end
          default: ;
        endcase
      end
      OP_ADDI, OP_ADDIU: begin
        dec_d.alu_op   = ALU_ADD;
        dec_d.alu_src  = ALUSRC_SEXT;
        dec_d.rdrt     = 1'b1;
        dec_d.regwrite = 1'b1;
      end
      OP_SLTI: begin
        dec_d.alu_op   = ALU_SLT;
        dec_d.alu_src  = ALUSRC_SEXT;
        dec_d.rdrt     = 1'b1;
        dec_d.regwrite = 1'b1;
      end
      OP_SLTIU: begin
        dec_d.alu_op   = ALU_SLTU;
        dec_d.alu_src  = ALUSRC_SEXT;
        dec_d.rdrt     = 1'b1;
        dec_d.regwrite = 1'b1;
      end
      OP_ANDI: begin
        dec_d.alu_op   = ALU_AND;
        dec_d.alu_src  = ALUSRC_ZEXT;
        dec_d.rdrt     = 1'b1;
        dec_d.regwrite = 1'b1;
      end
      OP_ORI: begin
        dec_d.alu_op   = ALU_OR;
        dec_d.alu_src  = ALUSRC_ZEXT;
        dec_d.rdrt     = 1'b1;
        dec_d.regwrite = 1'b1;
      end
      OP_XORI: begin
        dec_d.alu_op   = ALU_XOR;
        dec_d.alu_src  = ALUSRC_ZEXT;
        dec_d.rdrt     = 1'b1;
        dec_d.regwrite = 1'b1;
      end
      OP_LUI: begin
        // lui is done as zero-extended imm shifted left by 16
        dec_d.alu_op   = ALU_SLL;
        dec_d.shamt    = LUI_SHAMT;
        dec_d.alu_src  = ALUSRC_ZEXT;
        dec_d.rdrt     = 1'b1;
        dec_d.regwrite = 1'b1;
      end
      OP_LW: begin
        dec_d.gpio_in  = 1'b1;
        dec_d.rdrt     = 1'b1;
        dec_d.regwrite = 1'b1;
      end
      OP_SW: begin
        dec_d.gpio_out = 1'b1;
        dec_d.memwrite = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    ctrl        = dec_d;
    if (bubble) begin
      ctrl        = '0;
      ctrl.alu_op = ALU_AND;
    end
  end

  assign alu_op      = ctrl.alu_op;
  assign shamt_EX    = ctrl.shamt;
  assign enhilo_EX   = ctrl.enhilo;
  assign regsel_EX   = ctrl.regsel;
  assign regwrite_EX = ctrl.regwrite;
  assign rdrt_EX     = ctrl.rdrt;
  assign memwrite_EX = ctrl.memwrite;
  assign alu_src_EX  = ctrl.alu_src;
  assign GPIO_OUT    = ctrl.gpio_out;
  assign GPIO_IN     = ctrl.gpio_in;

`ifdef CONTROL_UNIT_ILLEGAL_FLAG_EN
  // Separate recognition table: an all-zero decode is not proof of an
  // unknown encoding (and/andi legitimately decode to alu_op 0000).
  logic known_d;

  always_comb begin
    known_d = 1'b0;
    case (i_type)
      OP_RTYPE: begin
        case (function_code)
          FN_ADD, FN_ADDU, FN_SUB, FN_SUBU, FN_AND, FN_OR, FN_XOR, FN_NOR,
          FN_SLT, FN_SLTU, FN_SLL, FN_SRL, FN_SRA, FN_MULT, FN_MULTU,
          FN_MFHI, FN_MFLO: known_d = 1'b1;
          default:          known_d = 1'b0;
        endcase
      end
      OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU, OP_ANDI, OP_ORI, OP_XORI,
      OP_LUI, OP_LW, OP_SW: known_d = 1'b1;
      default:              known_d = 1'b0;
    endcase
  end

  assign illegal = ~known_d & ~bubble;
`endif

endmodule

// File: tb/tb_control_unit.sv
// tb_control_unit: directed self-checking bench for control_unit.
// Build with +define+CONTROL_UNIT_ILLEGAL_FLAG_EN to also check 'illegal'.
module tb_control_unit;

  logic       clk;
  logic       rst;
  logic [5:0] i_type;
  logic [4:0] shamt;
  logic [5:0] function_code;
  logic       stall_FETCH;
  logic [3:0] alu_op;
  logic [4:0] shamt_EX;
  logic       enhilo_EX;
  logic [1:0] regsel_EX;
  logic       regwrite_EX;
  logic       rdrt_EX;
  logic       memwrite_EX;
  logic [1:0] alu_src_EX;
  logic       GPIO_OUT;
  logic       GPIO_IN;
`ifdef CONTROL_UNIT_ILLEGAL_FLAG_EN
  logic       illegal;
`endif

  int total = 0;
  int bad   = 0;

  control_unit dut (
    .clk          (clk),
    .rst          (rst),
    .i_type       (i_type),
    .shamt        (shamt),
    .function_code(function_code),
    .stall_FETCH  (stall_FETCH),
    .alu_op       (alu_op),
    .shamt_EX     (shamt_EX),
    .enhilo_EX    (enhilo_EX),
    .regsel_EX    (regsel_EX),
    .regwrite_EX  (regwrite_EX),
    .rdrt_EX      (rdrt_EX),
    .memwrite_EX  (memwrite_EX),
    .alu_src_EX   (alu_src_EX),
    .GPIO_OUT     (GPIO_OUT),
`ifdef CONTROL_UNIT_ILLEGAL_FLAG_EN
    .GPIO_IN      (GPIO_IN),
    .illegal      (illegal)
`else
    .GPIO_IN      (GPIO_IN)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Observed outputs packed as
  // {alu_op, shamt, enhilo, regsel, regwrite, rdrt, memwrite, alu_src, gout, gin}
  logic [18:0] obs;
  assign obs = {alu_op, shamt_EX, enhilo_EX, regsel_EX, regwrite_EX, rdrt_EX,
                memwrite_EX, alu_src_EX, GPIO_OUT, GPIO_IN};

  function automatic logic [18:0] ev(input logic [3:0] op, input logic [4:0] sh,
                                     input logic hl, input logic [1:0] rs,
                                     input logic rw, input logic rt, input logic mw,
                                     input logic [1:0] as, input logic go,
                                     input logic gi);
    return {op, sh, hl, rs, rw, rt, mw, as, go, gi};
  endfunction

  task automatic apply(input logic [5:0] op, input logic [5:0] fn, input logic [4:0] sh);
    i_type        = op;
    function_code = fn;
    shamt         = sh;
    #1;
  endtask

  task automatic test_reset();
    logic [18:0] exp;
    rst = 1'b1; stall_FETCH = 1'b0;
    apply(6'h08, 6'h00, 5'd0);
    @(negedge clk); #1;
    if (obs !== 19'd0) begin
      bad++; $display("FAIL reset_active got=%h want=%h", obs, 19'd0);
    end
    total++;
    $display("reset_active obs=%h", obs);
    rst = 1'b0; #1;
    if (obs !== 19'd0) begin
      bad++; $display("FAIL reset_first_cycle got=%h want=%h", obs, 19'd0);
    end
    total++;
    $display("reset_first_cycle obs=%h", obs);
    @(posedge clk); #1;
    exp = ev(4'b0100, 5'd0, 0, 2'b00, 1, 1, 0, 2'b01, 0, 0);
    if (obs !== exp) begin
      bad++; $display("FAIL reset_second_cycle got=%h want=%h", obs, exp);
    end
    total++;
    $display("reset_second_cycle obs=%h", obs);
  endtask

  task automatic test_rtype();
    logic [5:0]  fn  [8] = '{6'h03, 6'h2B, 6'h20, 6'h22, 6'h27, 6'h00, 6'h02, 6'h2A};
    logic [4:0]  sh  [8] = '{5'd7, 5'd7, 5'd9, 5'd3, 5'd1, 5'd0, 5'd31, 5'd4};
    logic [18:0] exp [8];
    exp[0] = ev(4'b1010, 5'd7,  0, 2'b00, 1, 0, 0, 2'b00, 0, 0);
    exp[1] = ev(4'b1101, 5'd0,  0, 2'b00, 1, 0, 0, 2'b00, 0, 0);
    exp[2] = ev(4'b0100, 5'd0,  0, 2'b00, 1, 0, 0, 2'b00, 0, 0);
    exp[3] = ev(4'b0101, 5'd0,  0, 2'b00, 1, 0, 0, 2'b00, 0, 0);
    exp[4] = ev(4'b0011, 5'd0,  0, 2'b00, 1, 0, 0, 2'b00, 0, 0);
    exp[5] = ev(4'b1000, 5'd0,  0, 2'b00, 1, 0, 0, 2'b00, 0, 0);
    exp[6] = ev(4'b1001, 5'd31, 0, 2'b00, 1, 0, 0, 2'b00, 0, 0);
    exp[7] = ev(4'b1100, 5'd0,  0, 2'b00, 1, 0, 0, 2'b00, 0, 0);
    for (int i = 0; i < 8; i++) begin
      apply(6'h00, fn[i], sh[i]);
      if (obs !== exp[i]) begin
        bad++; $display("FAIL rtype_fn%h got=%h want=%h", fn[i], obs, exp[i]);
      end
      total++;
      $display("rtype fn=%h sh=%0d obs=%h", fn[i], sh[i], obs);
    end
  endtask

  task automatic test_hilo();
    logic [5:0]  fn  [4] = '{6'h18, 6'h19, 6'h10, 6'h12};
    logic [18:0] exp [4];
    exp[0] = ev(4'b0110, 5'd0, 1, 2'b00, 0, 0, 0, 2'b00, 0, 0);
    exp[1] = ev(4'b0111, 5'd0, 1, 2'b00, 0, 0, 0, 2'b00, 0, 0);
    exp[2] = ev(4'b0000, 5'd0, 0, 2'b01, 1, 0, 0, 2'b00, 0, 0);
    exp[3] = ev(4'b0000, 5'd0, 0, 2'b10, 1, 0, 0, 2'b00, 0, 0);
    for (int i = 0; i < 4; i++) begin
      apply(6'h00, fn[i], 5'd5);
      if (obs !== exp[i]) begin
        bad++; $display("FAIL hilo_fn%h got=%h want=%h", fn[i], obs, exp[i]);
      end
      total++;
      $display("hilo fn=%h obs=%h", fn[i], obs);
    end
  endtask

  task automatic test_imm();
    logic [5:0]  op  [6] = '{6'h0D, 6'h0F, 6'h08, 6'h0B, 6'h0E, 6'h0C};
    logic [18:0] exp [6];
    exp[0] = ev(4'b0001, 5'd0,  0, 2'b00, 1, 1, 0, 2'b10, 0, 0);
    exp[1] = ev(4'b1000, 5'd16, 0, 2'b00, 1, 1, 0, 2'b10, 0, 0);
    exp[2] = ev(4'b0100, 5'd0,  0, 2'b00, 1, 1, 0, 2'b01, 0, 0);
    exp[3] = ev(4'b1101, 5'd0,  0, 2'b00, 1, 1, 0, 2'b01, 0, 0);
    exp[4] = ev(4'b0010, 5'd0,  0, 2'b00, 1, 1, 0, 2'b10, 0, 0);
    exp[5] = ev(4'b0000, 5'd0,  0, 2'b00, 1, 1, 0, 2'b10, 0, 0);
    for (int i = 0; i < 6; i++) begin
      // shamt/funct carry garbage from the immediate field; must be ignored
      apply(op[i], 6'h03, 5'd5);
      if (obs !== exp[i]) begin
        bad++; $display("FAIL imm_op%h got=%h want=%h", op[i], obs, exp[i]);
      end
      total++;
      $display("imm op=%h obs=%h", op[i], obs);
    end
  endtask

  task automatic test_gpio();
    logic [18:0] exp;
    apply(6'h23, 6'h18, 5'd2);
    exp = ev(4'b0000, 5'd0, 0, 2'b00, 1, 1, 0, 2'b00, 0, 1);
    if (obs !== exp) begin
      bad++; $display("FAIL gpio_lw got=%h want=%h", obs, exp);
    end
    total++;
    $display("gpio lw obs=%h", obs);
    apply(6'h2B, 6'h20, 5'd2);
    exp = ev(4'b0000, 5'd0, 0, 2'b00, 0, 0, 1, 2'b00, 1, 0);
    if (obs !== exp) begin
      bad++; $display("FAIL gpio_sw got=%h want=%h", obs, exp);
    end
    total++;
    $display("gpio sw obs=%h", obs);
  endtask

  task automatic test_stall_illegal();
    logic [18:0] exp;
    stall_FETCH = 1'b1;
    apply(6'h00, 6'h20, 5'd0);
    if (obs !== 19'd0) begin
      bad++; $display("FAIL stall_add got=%h want=%h", obs, 19'd0);
    end
    total++;
    $display("stall add obs=%h", obs);
`ifdef CONTROL_UNIT_ILLEGAL_FLAG_EN
    apply(6'h3F, 6'h00, 5'd0);
    if (illegal !== 1'b0) begin
      bad++; $display("FAIL illegal_in_bubble got=%b want=0", illegal);
    end
    total++;
`endif
    stall_FETCH = 1'b0;
    apply(6'h00, 6'h20, 5'd0);
    exp = ev(4'b0100, 5'd0, 0, 2'b00, 1, 0, 0, 2'b00, 0, 0);
    if (obs !== exp) begin
      bad++; $display("FAIL unstall_add got=%h want=%h", obs, exp);
    end
    total++;
    $display("unstall add obs=%h", obs);
`ifdef CONTROL_UNIT_ILLEGAL_FLAG_EN
    if (illegal !== 1'b0) begin
      bad++; $display("FAIL illegal_add got=%b want=0", illegal);
    end
    total++;
`endif
    apply(6'h3F, 6'h20, 5'd3);
    if (obs !== 19'd0) begin
      bad++; $display("FAIL unknown_op got=%h want=%h", obs, 19'd0);
    end
    total++;
    $display("unknown op=3f obs=%h", obs);
`ifdef CONTROL_UNIT_ILLEGAL_FLAG_EN
    if (illegal !== 1'b1) begin
      bad++; $display("FAIL illegal_op3f got=%b want=1", illegal);
    end
    total++;
`endif
    apply(6'h00, 6'h01, 5'd3);
    if (obs !== 19'd0) begin
      bad++; $display("FAIL unknown_fn got=%h want=%h", obs, 19'd0);
    end
    total++;
    $display("unknown fn=01 obs=%h", obs);
`ifdef CONTROL_UNIT_ILLEGAL_FLAG_EN
    if (illegal !== 1'b1) begin
      bad++; $display("FAIL illegal_fn01 got=%b want=1", illegal);
    end
    total++;
`endif
  endtask

  initial begin
    rst = 1'b1; stall_FETCH = 1'b0;
    i_type = '0; shamt = '0; function_code = '0;
    test_reset();
    test_rtype();
    test_hilo();
    test_imm();
    test_gpio();
    test_stall_illegal();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
